fir_output_tx: RTL and testbench

//   Far-end sink for fir_filter results: captures each 18-bit filter output sample into a small FIFO.

---
 rtl/fir_output_tx_pkg.sv | 16 +
 rtl/fir_output_tx_sync_fifo.sv | 66 ++++++
 rtl/fir_output_tx.sv | 127 ++++++++++++
 tb/tb_fir_output_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_output_tx_pkg.sv
// Shared definitions for the fir_output_tx serial sink: frame geometry and
// the transmit state encoding.
package fir_output_tx_pkg;

  localparam int FRAME_BYTES = 3;
  localparam int SAMPLE_W    = 8 * FRAME_BYTES;
  localparam int DATA_W_DEF  = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/fir_output_tx_sync_fifo.sv
// Synchronous sample FIFO with registered read data, count and flags.
// When full, a pop in the same cycle frees the slot a push then fills.
module fir_output_tx_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + CNT_ONE;
          full  <= (count == CNT_HIGH);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CNT_ONE;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

  // Storage and read register carry data only; the read returns the old
  // entry even when a full-FIFO push overwrites that slot on the same edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/fir_output_tx.sv
// Buffers fir_filter output samples and ships each one as three 8N1 UART
// bytes (sign-extended to 24 bits, least significant byte first).
module fir_output_tx
  import fir_output_tx_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    data_in,
  input  logic                        data_valid,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [1:0]        LAST_BYTE = 2'(FRAME_BYTES - 1);

  function automatic logic [SAMPLE_W-1:0] sign_extend(input logic signed [DATA_W-1:0] s);
    return {{(SAMPLE_W - DATA_W){s[DATA_W-1]}}, s};
  endfunction

  tx_state_t           state;
  tx_state_t           state_nxt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [1:0]          byte_idx;
  logic [SAMPLE_W-1:0] shift;
  logic                bit_end;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rd_data;

  fir_output_tx_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (data_valid),
    .pop     (fifo_pop),
    .wr_data (data_in),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = START;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          if (byte_idx != LAST_BYTE) begin
            state_nxt = START;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  // Control: every state is entered with baud_cnt at zero, so bit
  // boundaries never drift across bits, bytes or samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + BAUD_ONE;
      if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (fifo_pop)                        byte_idx <= '0;
      else if (state == STOP && bit_end)   byte_idx <= byte_idx + 2'd1;
      // With no pop this edge, the FIFO ends non-empty exactly when it
      // already was or a push arrives; a pop always moves on to START.
      busy     <= (state_nxt != IDLE) | ~fifo_empty | data_valid;
      overflow <= overflow | (data_valid & fifo_full & ~fifo_pop);
    end
  end

  // Sample is loaded at the end of the first start bit, after the FIFO read
  // register has settled; later bytes fall out of the same shifter.
  always_ff @(posedge clk) begin
    if (state == START && bit_end && byte_idx == 2'd0)
      shift <= sign_extend(fifo_rd_data);
    else if (state == DATA && bit_end)
      shift <= shift >> 1;
  end

endmodule

// File: tb/tb_fir_output_tx.sv
// Directed bench for fir_output_tx: stimulus queues expected 24-bit words,
// a UART receiver on the tx line pops and compares every received sample.
module tb_fir_output_tx;

  localparam int DATA_W     = 18;
  localparam int FIFO_DEPTH = 8;
  localparam int BAUD_DIV   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              tx;
  logic              busy;
  logic [3:0]        fifo_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int bytes_rx = 0;
  logic [23:0] exp_q[$];

  // Directed vectors and their hand-computed 24-bit sign extensions.
  logic [DATA_W-1:0] vec_in  [10] = '{18'h00001, 18'h20000, 18'h1FFFF, 18'h3FFFE, 18'h0A5A5,
                                      18'h25A5A, 18'h12345, 18'h3C000, 18'h00080, 18'h2FFFF};
  logic [23:0]       vec_exp [10] = '{24'h000001, 24'hFE0000, 24'h01FFFF, 24'hFFFFFE, 24'h00A5A5,
                                      24'hFE5A5A, 24'h012345, 24'hFFC000, 24'h000080, 24'hFEFFFF};

  always #5 clk = ~clk;

  fir_output_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample for a single edge; queue its expected word if accepted.
  task automatic push(input logic [DATA_W-1:0] d, input logic [23:0] e, input bit accept);
    data_in    = d;
    data_valid = 1'b1;
    if (accept) exp_q.push_back(e);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  // UART receiver: samples mid-bit, assembles 3 bytes, compares with queue.
  initial begin : monitor
    int cnt;
    int idx;
    int nbyte;
    bit on;
    logic [7:0]  b;
    logic [23:0] word;
    on = 1'b0; cnt = 0; nbyte = 0; b = '0; word = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        on = 1'b0;
        nbyte = 0;
        exp_q.delete();
      end else if (!on) begin
        if (tx == 1'b0) begin
          on = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % BAUD_DIV == BAUD_DIV / 2) begin
          idx = cnt / BAUD_DIV;
          if (idx == 0) begin
            check("start_bit", tx, 0);
          end else if (idx <= 8) begin
            b[idx-1] = tx;
          end else begin
            check("stop_bit", tx, 1);
            word[nbyte*8 +: 8] = b;
            bytes_rx++;
            nbyte++;
            on = 1'b0;
            if (nbyte == 3) begin
              nbyte = 0;
              if (exp_q.size() == 0) begin
                check("unexpected_sample", word, 24'hxxxxxx);
              end else begin
                check("sample", word, exp_q.pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int b0;
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    // Single sample: bytes 05,00,FE
    b0 = bytes_rx;
    push(18'h20005, 24'hFE0005, 1'b1);
    check("single_count", fifo_count, 1);
    check("single_busy", busy, 1);
    tick();
    check("single_latency_tx", tx, 0);
    check("single_pop_count", fifo_count, 0);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("single_busy_len", n, 480);
    wait_idle("single_drain", 100);
    check("single_bytes", bytes_rx - b0, 3);

    // Three consecutive samples: nine frames back-to-back
    b0 = bytes_rx;
    push(18'h00123, 24'h000123, 1'b1);
    push(18'h3FFFF, 24'hFFFFFF, 1'b1);
    push(18'h1ABCD, 24'h01ABCD, 1'b1);
    n = 1;
    while (busy && n < 4000) begin
      tick();
      n++;
    end
    check("burst3_active_len", n, 1440);
    wait_idle("burst3_drain", 100);
    check("burst3_bytes", bytes_rx - b0, 9);

    // Ten consecutive samples: ninth fills the FIFO, tenth is dropped
    b0 = bytes_rx;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) push(vec_in[i], vec_exp[i], 1'b1);
      else       push(18'h15555, 24'h015555, 1'b0);
      if (i == 8) begin
        check("ovf_before_drop", overflow, 0);
        check("ovf_full_count", fifo_count, 8);
      end
      if (i == 9) begin
        check("ovf_after_drop", overflow, 1);
        check("ovf_count_held", fifo_count, 8);
      end
    end
    wait_idle("ovf_drain", 6000);
    check("ovf_bytes", bytes_rx - b0, 27);
    check("ovf_sticky", overflow, 1);
    rst = 1'b0;
    tick();
    check("ovf_cleared", overflow, 0);
    rst = 1'b1;
    tick();

    // Full FIFO with a push on the same edge as the STOP->START pop
    b0 = bytes_rx;
    for (int i = 0; i < 9; i++) push(vec_in[i], vec_exp[i], 1'b1);
    for (int i = 0; i < 472; i++) tick();
    check("full_before_pop", fifo_count, 8);
    check("full_tx_stop", tx, 1);
    push(18'h2FFFF, 24'hFEFFFF, 1'b1);
    check("full_pop_push_count", fifo_count, 8);
    check("full_pop_push_ovf", overflow, 0);
    check("full_next_start", tx, 0);
    wait_idle("full_drain", 6000);
    check("full_bytes", bytes_rx - b0, 30);

    // Reset during byte1 data bit 3 abandons the frame
    push(vec_in[4], vec_exp[4], 1'b1);
    push(vec_in[5], vec_exp[5], 1'b1);
    push(vec_in[6], vec_exp[6], 1'b1);
    for (int i = 0; i < 229; i++) tick();
    check("midrst_count_before", fifo_count, 2);
    rst = 1'b0;
    tick();
    check("midrst_tx", tx, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (tx == 1'b0) n++;
    end
    check("midrst_no_start", n, 0);

    // Recovery after reset
    b0 = bytes_rx;
    push(18'h00055, 24'h000055, 1'b1);
    wait_idle("recover_drain", 1000);
    check("recover_bytes", bytes_rx - b0, 3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
